// File: rtl/miss_request_arbiter_pkg.sv
// miss_request_arbiter_pkg: shared types for the miss request arbiter
// Holds the entry-state and issue-FSM enums plus the entry record;
// entry field widths follow the default line-address width and requester count.
package miss_request_arbiter_pkg;
  localparam int MRA_ADDR_W = 58;
  localparam int MRA_NREQ = 2;
  typedef enum logic [1:0] {FREE, PENDING, INFLIGHT} ent_state_t;
  typedef enum logic {IDLE, ISSUE} iss_state_t;
  typedef struct packed {
    ent_state_t st;
    logic [MRA_ADDR_W-1:0] addr;
    logic [MRA_NREQ-1:0] mask;
  } entry_t;
endpackage

// File: rtl/miss_request_arbiter_if.sv
// miss_request_arbiter_if: requester, memory-bus and fill-notify signals
// master: arbiter side (drives req_ready, bus_req/addr/tag, resp_*); slave: environment side.
interface miss_request_arbiter_if
  import miss_request_arbiter_pkg::*;
#(
  parameter int ADDR_W = MRA_ADDR_W,
  parameter int LOG_DEPTH = 2,
  parameter int NREQ = MRA_NREQ
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0][ADDR_W-1:0] req_addr;
  logic [NREQ-1:0] req_ready;
  logic bus_req;
  logic [ADDR_W-1:0] bus_addr;
  logic [LOG_DEPTH-1:0] bus_tag;
  logic bus_reqack;
  logic bus_resp;
  logic [LOG_DEPTH-1:0] bus_resp_tag;
  logic resp_valid;
  logic [ADDR_W-1:0] resp_addr;
  logic [NREQ-1:0] resp_mask;
  modport master(
    input req_valid, req_addr, bus_reqack, bus_resp, bus_resp_tag,
    output req_ready, bus_req, bus_addr, bus_tag, resp_valid, resp_addr, resp_mask
  );
  modport slave(
    output req_valid, req_addr, bus_reqack, bus_resp, bus_resp_tag,
    input req_ready, bus_req, bus_addr, bus_tag, resp_valid, resp_addr, resp_mask
  );
endinterface

// File: rtl/miss_request_arbiter_rr.sv
// mra_rr_arbiter: round-robin one-hot grant among N requesters
// Ports: clk, reset (async active-low), req (request vector), adv (winner accepted), gnt (one-hot grant).
module mra_rr_arbiter #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic [N-1:0] req,
  input  logic adv,
  output logic [N-1:0] gnt
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr_q, ptr_d, idx, j;
  always_comb begin
    gnt = '0;
    idx = ptr_q;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = PW'((int'(ptr_q) + k) % N);
      if (req[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        idx = j;
      end
    end
    ptr_d = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr_q <= '0;
    else if (adv) ptr_q <= ptr_d;
endmodule

// File: rtl/miss_request_arbiter.sv
// miss_request_arbiter: merges cache misses into outstanding entries and issues them to memory
// Ports: clk, reset (async active-low), bus (miss_request_arbiter_if.master: requesters,
// memory request/response, fill notify), full, stat_alloc/stat_merge/stat_stall.
// Counters are built only when MISS_REQUEST_ARBITER_STATS_EN is defined; otherwise tied to 0.
module miss_request_arbiter
  import miss_request_arbiter_pkg::*;
#(
  parameter int ADDR_W = MRA_ADDR_W,
  parameter int DEPTH = 4,
  parameter int LOG_DEPTH = 2,
  parameter int NREQ = MRA_NREQ
) (
  input  logic clk,
  input  logic reset,
  miss_request_arbiter_if.master bus,
  output logic full,
  output logic [31:0] stat_alloc,
  output logic [31:0] stat_merge,
  output logic [31:0] stat_stall
);
  localparam int NW = NREQ > 1 ? $clog2(NREQ) : 1;
  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];
  iss_state_t iss_q;
  logic [LOG_DEPTH-1:0] tag_q, hit_idx, free_idx, pend_idx;
  logic [ADDR_W-1:0] bus_addr_q, resp_addr_q, win_addr;
  logic [NREQ-1:0] gnt, resp_mask_q;
  logic [NW-1:0] win_idx;
  logic any_hit, any_free, any_pend, resp_hit, accept, resp_valid_q;
  mra_rr_arbiter #(.N(NREQ)) u_rr (
    .clk(clk), .reset(reset), .req(bus.req_valid), .adv(accept), .gnt(gnt)
  );
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) if (gnt[i]) win_idx = NW'(i);
    win_addr = bus.req_addr[win_idx];
    any_hit = 1'b0;
    any_free = 1'b0;
    any_pend = 1'b0;
    hit_idx = '0;
    free_idx = '0;
    pend_idx = '0;
    full = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].st != FREE && ent_q[i].addr == win_addr) begin
        any_hit = 1'b1;
        hit_idx = LOG_DEPTH'(i);
      end
      if (ent_q[i].st == FREE) begin
        any_free = 1'b1;
        free_idx = LOG_DEPTH'(i);
      end
      if (ent_q[i].st == PENDING) begin
        any_pend = 1'b1;
        pend_idx = LOG_DEPTH'(i);
      end
      full = full & (ent_q[i].st != FREE);
    end
    resp_hit = bus.bus_resp && ent_q[bus.bus_resp_tag].st == INFLIGHT;
    // a match on the entry being freed right now must retry rather than merge into a dying entry;
    // any_free comes from registered state, so a freed slot is never reused in the same cycle
    accept = |gnt && (any_hit ? !(resp_hit && bus.bus_resp_tag == hit_idx) : any_free);
    bus.req_ready = accept ? gnt : '0;
    ent_d = ent_q;
    if (iss_q == ISSUE && bus.bus_reqack) ent_d[tag_q].st = INFLIGHT;
    if (resp_hit) begin
      ent_d[bus.bus_resp_tag].st = FREE;
      ent_d[bus.bus_resp_tag].mask = '0;
    end
    if (accept && any_hit) ent_d[hit_idx].mask = ent_q[hit_idx].mask | gnt;
    if (accept && !any_hit) ent_d[free_idx] = '{st: PENDING, addr: win_addr, mask: gnt};
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      resp_valid_q <= 1'b0;
      resp_addr_q <= '0;
      resp_mask_q <= '0;
    end else begin
      ent_q <= ent_d;
      resp_valid_q <= resp_hit;
      resp_mask_q <= resp_hit ? ent_q[bus.bus_resp_tag].mask : '0;
      if (resp_hit) resp_addr_q <= ent_q[bus.bus_resp_tag].addr;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      iss_q <= IDLE;
      tag_q <= '0;
      bus_addr_q <= '0;
    end else if (iss_q == IDLE && any_pend) begin
      iss_q <= ISSUE;
      tag_q <= pend_idx;
      bus_addr_q <= ent_q[pend_idx].addr;
    end else if (iss_q == ISSUE && bus.bus_reqack) iss_q <= IDLE;
  assign bus.bus_req = iss_q == ISSUE;
  assign bus.bus_addr = bus_addr_q;
  assign bus.bus_tag = tag_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_addr = resp_addr_q;
  assign bus.resp_mask = resp_mask_q;
  a_resp_inflight: assert property (@(posedge clk) disable iff (!reset)
    bus.bus_resp |-> ent_q[bus.bus_resp_tag].st == INFLIGHT);
`ifdef MISS_REQUEST_ARBITER_STATS_EN
  logic [31:0] alloc_q, merge_q, stall_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      alloc_q <= '0;
      merge_q <= '0;
      stall_q <= '0;
    end else begin
      alloc_q <= alloc_q + {31'b0, accept && !any_hit};
      merge_q <= merge_q + {31'b0, accept && any_hit};
      stall_q <= stall_q + {31'b0, |bus.req_valid && !accept};
    end
  assign stat_alloc = alloc_q;
  assign stat_merge = merge_q;
  assign stat_stall = stall_q;
`else
  assign stat_alloc = '0;
  assign stat_merge = '0;
  assign stat_stall = '0;
`endif
endmodule

// File: doc/miss_request_arbiter.md
MISS_REQUEST_ARBITER -- requirements
Module: miss_request_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_W, 58, line-address width; DEPTH, 4, outstanding-miss entries; LOG_DEPTH, 2, log2(DEPTH); NREQ, 2, requester count.
REQ-002 SHALL have ports (name, direction, width, meaning): clk, in, 1, the single clock; reset, in, 1, asynchronous active-low reset.
REQ-003 SHALL have ports: req_valid, in, NREQ, per-requester miss valid; req_addr, in, NREQ x ADDR_W, miss line address; req_ready, out, NREQ, per-requester accept.
REQ-004 SHALL have ports: bus_req, out, 1, read request to memory; bus_addr, out, ADDR_W, request address; bus_tag, out, LOG_DEPTH, entry index; bus_reqack, in, 1, bus accepted request.
REQ-005 SHALL have ports: bus_resp, in, 1, fill returned; bus_resp_tag, in, LOG_DEPTH, entry index of fill.
REQ-006 SHALL have ports: resp_valid, out, 1, fill notify; resp_addr, out, ADDR_W, filled line; resp_mask, out, NREQ, requesters waiting on it.
REQ-007 SHALL have ports: full, out, 1, all entries non-FREE; stat_alloc, stat_merge, stat_stall, out, 32 each, statistics counters.

Function
REQ-008 Each entry SHALL hold state FREE/PENDING/INFLIGHT, address, and NREQ-bit waiter mask.
REQ-009 One requester per cycle SHALL be accepted, chosen round-robin among asserted req_valid; the priority pointer advances to one past the accepted requester only on acceptance (req_valid & req_ready).
REQ-010 req_ready SHALL be asserted only for the round-robin winner, and only if it can merge or allocate that cycle.
REQ-011 Merge: if winner address equals a PENDING or INFLIGHT entry address, the request SHALL be accepted, that entry's waiter bit set, and no entry allocated.
REQ-012 Allocate: with no match and a FREE entry, the lowest-index FREE entry SHALL become PENDING with address and a one-hot waiter mask at the next edge.
REQ-013 With no match and full=1, req_ready SHALL be 0 for all requesters.
REQ-014 If the matching entry is being freed by bus_resp this cycle, req_ready SHALL be 0 (no merge, no allocate); the request is retried.
REQ-015 An entry freed this cycle SHALL NOT be allocated in the same cycle (no bypass).
REQ-016 Issue FSM states IDLE and ISSUE: IDLE->ISSUE when any entry is PENDING, latching the lowest-index PENDING entry; bus_req=1 in ISSUE with bus_addr/bus_tag stable until bus_reqack; on bus_reqack the entry becomes INFLIGHT and FSM returns to IDLE.
REQ-017 Minimum latency SHALL be: accept at edge N, bus_req at N+1, entry INFLIGHT earliest at N+2.
REQ-018 On bus_resp, entry bus_resp_tag SHALL become FREE at the next edge; resp_valid SHALL pulse for exactly that one cycle with that entry's resp_addr and resp_mask.
REQ-019 bus_resp to a non-INFLIGHT entry SHALL be ignored and flagged by an assertion.
REQ-020 Merges into a PENDING or INFLIGHT entry SHALL OR into the waiter mask; a merge and a response to different entries in one cycle SHALL both take effect.
REQ-021 full SHALL equal AND of (state != FREE) over all entries, combinationally from state registers.

Reset
REQ-022 While reset=0: all entries FREE, waiter masks 0, FSM IDLE, round-robin pointer 0, bus_req=0, resp_valid=0, resp_mask=0, full=0, counters 0.
REQ-023 Reset asserted mid-issue SHALL drop bus_req immediately (asynchronous) and discard all outstanding entries.

Configuration
REQ-024 Macro MISS_REQUEST_ARBITER_STATS_EN defined: stat_alloc counts allocations, stat_merge counts merges, stat_stall counts cycles with any req_valid and no acceptance; all wrap at 2^32.
REQ-025 Macro undefined: stat_* ports SHALL exist and be tied to 0, and no counter registers SHALL be built.

Structure
REQ-026 A shared package SHALL hold the entry-state enum (FREE, PENDING, INFLIGHT), the issue-FSM enum, and the entry struct typedef.
REQ-027 The round-robin selector SHALL be a sub-module named mra_rr_arbiter (inputs: request vector, advance; output: one-hot grant).

Verification
REQ-028 Single miss: req0 addr 0x100 -> accepted edge N, bus_req/bus_addr 0x100/tag 0 at N+1, bus_reqack -> bus_resp tag 0 -> resp_valid with resp_addr 0x100, resp_mask 2'b01.
REQ-029 Merge: req0 and req1 both addr 0x200 -> one bus_req only; response -> resp_mask 2'b11; stat_merge=1 (macro defined).
REQ-030 Full: 4 distinct addresses allocated, 5th distinct -> full=1, req_ready=0; bus_resp tag 2 -> 5th accepted the cycle after the free edge into entry 2.
REQ-031 Fairness: both requesters continuously valid with distinct addresses -> grants alternate 0,1,0,1.
REQ-032 Free/merge collision: bus_resp tag 0 (addr 0x300) same cycle as req1 addr 0x300 -> req_ready=0 that cycle; next cycle allocated fresh, new bus_req for 0x300.
REQ-033 Reset mid-issue: bus_req=1 awaiting bus_reqack, reset=0 -> bus_req=0 immediately, full=0, all counters 0.
